// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and
// the step-counter width helper.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0110,
      OP_SLT = 4'b0111,
      OP_NOR = 4'b1100,
      OP_MUL = 4'b1000,
      OP_DIV = 4'b1010
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   // The step counter must hold the value WIDTH itself.
   function automatic int cntWidth(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier and (with ALU_SEQ_DIVIDE_EN)
// restoring divider; one step per cycle under control of alu_seq's FSM.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_isDiv,
   input  logic [WIDTH-1:0] i_opA,
   input  logic [WIDTH-1:0] i_opB,
   output logic             o_last,
   output logic [WIDTH-1:0] o_nextLo,
   output logic [WIDTH-1:0] o_nextHi
);

   localparam int CW = cntWidth(WIDTH);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_operand;
   logic [CW-1:0]    r_count;

   logic [WIDTH:0]   w_mulSum;
   logic [WIDTH-1:0] w_mulHi;
   logic [WIDTH-1:0] w_mulLo;

   // Multiply: add the multiplicand when the multiplier LSB is set, then
   // shift the {hi,lo} pair right so the product builds up in both halves.
   always_comb begin
      w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
      w_mulHi  = w_mulSum[WIDTH:1];
      w_mulLo  = {w_mulSum[0], r_lo[WIDTH-1:1]};
   end

`ifdef ALU_SEQ_DIVIDE_EN
   logic             r_isDiv;
   logic [WIDTH:0]   w_divShift;
   logic             w_divBorrow;
   logic [WIDTH-1:0] w_divDiff;
   logic [WIDTH-1:0] w_divHi;
   logic [WIDTH-1:0] w_divLo;

   // Divide: shift the next dividend bit into the remainder and subtract
   // the divisor only if it fits; the dividend register fills with quotient.
   always_comb begin
      w_divShift  = {r_hi, r_lo[WIDTH-1]};
      w_divBorrow = (w_divShift < {1'b0, r_operand});
      w_divDiff   = w_divShift[WIDTH-1:0] - r_operand;
      if (w_divBorrow) begin
         w_divHi = w_divShift[WIDTH-1:0];
         w_divLo = {r_lo[WIDTH-2:0], 1'b0};
      end else begin
         w_divHi = w_divDiff;
         w_divLo = {r_lo[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_isDiv <= 1'b0;
      end else if (i_load) begin
         r_isDiv <= i_isDiv;
      end
   end

   assign o_nextHi = r_isDiv ? w_divHi : w_mulHi;
   assign o_nextLo = r_isDiv ? w_divLo : w_mulLo;
`else
   logic w_unusedIsDiv;

   assign w_unusedIsDiv = i_isDiv;
   assign o_nextHi      = w_mulHi;
   assign o_nextLo      = w_mulLo;
`endif

   // Load clears the high half and latches both operands; each step
   // commits one iteration and counts down towards the final one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_operand <= '0;
         r_count   <= '0;
      end else if (i_load) begin
         r_hi      <= '0;
         r_lo      <= i_opA;
         r_operand <= i_opB;
         r_count   <= CW'(WIDTH);
      end else if (i_step) begin
         r_hi      <= o_nextHi;
         r_lo      <= o_nextLo;
         r_count   <= r_count - CW'(1);
      end
   end

   assign o_last = (r_count == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/ready/done handshake and registered outputs.
// Define ALU_SEQ_DIVIDE_EN to enable unsigned DIV on code 1010.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] data_in_0,
   input  logic [WIDTH-1:0] data_in_1,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             illegal
);

   alu_state_t       r_state;
   logic             r_ready;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_resultHi;
   logic             r_zero;
   logic             r_overflow;
   logic             r_illegal;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_single;
   logic             w_overflow;
   logic             w_illegal;
   logic             w_isMulDiv;
   logic             w_isDiv;
   logic             w_load;
   logic             w_step;
   logic             w_mdLast;
   logic [WIDTH-1:0] w_mdLo;
   logic [WIDTH-1:0] w_mdHi;

   // Single-cycle datapath and decode of which codes need the iterative engine.
   always_comb begin
      w_sum      = data_in_0 + data_in_1;
      w_diff     = data_in_0 - data_in_1;
      w_single   = '0;
      w_overflow = 1'b0;
      w_illegal  = 1'b0;
      w_isMulDiv = 1'b0;
      w_isDiv    = 1'b0;
      case (alu_control)
         OP_AND: w_single = data_in_0 & data_in_1;
         OP_OR:  w_single = data_in_0 | data_in_1;
         OP_NOR: w_single = ~(data_in_0 | data_in_1);
         OP_ADD: begin
            w_single   = w_sum;
            w_overflow = (data_in_0[WIDTH-1] == data_in_1[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != data_in_0[WIDTH-1]);
         end
         OP_SUB: begin
            w_single   = w_diff;
            w_overflow = (data_in_0[WIDTH-1] != data_in_1[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != data_in_0[WIDTH-1]);
         end
         OP_SLT: w_single = {{(WIDTH-1){1'b0}}, ($signed(data_in_0) < $signed(data_in_1))};
         OP_MUL: w_isMulDiv = 1'b1;
`ifdef ALU_SEQ_DIVIDE_EN
         OP_DIV: begin
            w_isMulDiv = 1'b1;
            w_isDiv    = 1'b1;
         end
`endif
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_load = (r_state == IDLE) && start && w_isMulDiv;
   assign w_step = (r_state == RUN);

   alu_seq_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_isDiv  (w_isDiv),
      .i_opA    (data_in_0),
      .i_opB    (data_in_1),
      .o_last   (w_mdLast),
      .o_nextLo (w_mdLo),
      .o_nextHi (w_mdHi)
   );

`ifdef ALU_SEQ_DIVIDE_EN
   logic r_divPending;
   logic r_divByZero;

   // Divide-by-zero is known at acceptance but only reported with the result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_divPending <= 1'b0;
         r_divByZero  <= 1'b0;
      end else begin
         if (w_load) begin
            r_divPending <= w_isDiv && (data_in_1 == '0);
         end
         if (r_state == IDLE && start && !w_isMulDiv) begin
            r_divByZero <= 1'b0;
         end else if (r_state == RUN && w_mdLast) begin
            r_divByZero <= r_divPending;
         end
      end
   end

   assign div_by_zero = r_divByZero;
`else
   assign div_by_zero = 1'b0;
`endif

   // Control FSM; result and flags are written only on entry to DONE and
   // then hold until the next operation completes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_resultHi <= '0;
         r_zero     <= 1'b1;
         r_overflow <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ready <= 1'b0;
                  if (w_isMulDiv) begin
                     r_state <= RUN;
                  end else begin
                     r_state    <= DONE;
                     r_done     <= 1'b1;
                     r_result   <= w_single;
                     r_resultHi <= '0;
                     r_zero     <= (w_single == '0);
                     r_overflow <= w_overflow;
                     r_illegal  <= w_illegal;
                  end
               end
            end
            RUN: begin
               if (w_mdLast) begin
                  r_state    <= DONE;
                  r_done     <= 1'b1;
                  r_result   <= w_mdLo;
                  r_resultHi <= w_mdHi;
                  r_zero     <= (w_mdLo == '0);
                  r_overflow <= 1'b0;
                  r_illegal  <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready     = r_ready;
   assign done      = r_done;
   assign result    = r_result;
   assign result_hi = r_resultHi;
   assign zero      = r_zero;
   assign overflow  = r_overflow;
   assign illegal   = r_illegal;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the combinational 32-bit ALU. Single-cycle logic/arithmetic ops use the existing 4-bit `alu_control` encoding. Iterative unsigned multiply and divide take WIDTH cycles. A start/ready/done handshake and registered outputs let the CPU's execute stage stall on long operations.

## Interface
- `WIDTH`, default 32: operand/result width, must be ≥ 4.
- `clock`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; accepted on a rising edge when `ready`=1.
- `alu_control`  in  4: operation select, sampled at acceptance.
- `data_in_0`  in  WIDTH: first operand, sampled at acceptance.
- `data_in_1`  in  WIDTH: second operand, sampled at acceptance.
- `ready`  out  1: block idle, can accept.
- `done`  out  1: one-cycle pulse, result valid.
- `result`  out  WIDTH: primary result (product low / quotient).
- `result_hi`  out  WIDTH: product high / remainder; 0 for other ops.
- `zero`  out  1: `result`==0.
- `overflow`  out  1: signed overflow, ADD/SUB only.
- `div_by_zero`  out  1: DIV with `data_in_1`==0.
- `illegal`  out  1: unsupported `alu_control` code.

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed, result 1/0)
  - 1100 NOR
  - 1000 MUL (unsigned, 2·WIDTH product split hi/lo)
  - 1010 DIV (unsigned)
- Any other code: `result`=0, `illegal`=1, single-cycle path.
- FSM states: IDLE, RUN, DONE.
  - IDLE + accepted single-cycle op → DONE. Result computed from the sampled operands and registered.
  - IDLE + accepted MUL/DIV → RUN with counter = WIDTH.
  - RUN: one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle. Counter decrements; at counter 1 → DONE.
  - DONE → IDLE unconditionally.
- `ready`=1 only in IDLE. `start` in RUN/DONE is ignored; no queueing.
- Outputs (`result`, `result_hi`, flags) update only on entry to DONE. They hold until the next DONE.
- ADD/SUB wrap modulo 2^WIDTH. `overflow` = operand signs equal (ADD) or differing (SUB) and result sign ≠ `data_in_0` sign.
- DIV by zero: `result` = all ones, `result_hi` = `data_in_0`, `div_by_zero`=1. Still takes the full WIDTH+1 latency.
- All flags not relevant to the current op are driven 0.

## Timing
- Reset values: `ready`=1, `done`=0. `result`, `result_hi`, `zero`… all 0 except `zero`=1. FSM goes to IDLE and the counter is cleared.
- Reset asserted mid-RUN aborts the operation immediately; no `done` is produced.
- Single-cycle ops: accepted at edge N, `done`=1 during cycle N+1, `ready`=1 again from edge N+2.
- MUL/DIV: accepted at edge N, `done`=1 during cycle N+WIDTH+1, `ready` from N+WIDTH+2.
- Throughput is therefore one op per 2 cycles (single-cycle) or WIDTH+2 cycles (MUL/DIV).
- Operand inputs may change freely after acceptance.

## Configuration
- `ALU_SEQ_DIVIDE_EN` defined: code 1010 performs DIV as above, and the datapath contains the subtract/restore logic.
- Not defined: 1010 is treated as illegal (single cycle, `result`=0, `illegal`=1). `div_by_zero` is tied to 0. No divider logic is synthesised.

## Structure
- Package `alu_pkg`:
  - Enum `alu_op_t` holding all control codes.
  - Enum `alu_state_t` (IDLE, RUN, DONE).
  - Counter-width localparam function `$clog2(WIDTH+1)`.
- Sub-module `alu_seq_muldiv` holds the iterative engine. It contains the WIDTH-bit accumulator/remainder register pair, the shift logic and the step counter. It takes load/step controls from the top-level FSM. The single-cycle ops and FSM stay in `alu_seq`.

## Test plan
- Reset mid-MUL: assert `reset_n`=0 at cycle 10 of a MUL → `ready`=1, `result`=0, `zero`=1, no `done` pulse.
- WIDTH=32, ADD 0x7FFFFFFF + 1 → `done` 1 cycle after accept, `result`=0x80000000, `overflow`=1, `zero`=0. Then SUB 5−5 → `result`=0, `zero`=1, `overflow`=0.
- SLT signed: 0xFFFFFFFF vs 0x00000001 → `result`=1. Swapped operands → `result`=0.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → `done` exactly 33 cycles after accept, `result_hi`=0xFFFFFFFE, `result`=0x00000001. A `start` pulsed during RUN is ignored.
- With `ALU_SEQ_DIVIDE_EN`: DIV 100 ÷ 7 → `result`=14, `result_hi`=2 after 33 cycles. DIV 9 ÷ 0 → `result`=0xFFFFFFFF, `result_hi`=9, `div_by_zero`=1.
- Without the macro: 1010 → `done` after 1 cycle, `illegal`=1, `result`=0. Code 0011 → same response in both builds.
